sobel_filter: RTL
=================

# sobel_filter

Streaming 3×3 Sobel edge detector that sits directly downstream of the grayscale stage in the sobel pipeline. It pops 8-bit grayscale pixels from the grayscale output FIFO in raster order, keeps two image rows plus three pixels in a line buffer, and computes a gradient magnitude per pixel. Results are pushed to the next FIFO, typically the writer/sink. Each frame produces exactly one output pixel per input pixel, and border pixels are forced to zero.

## Interface
- FIFO_DWIDTH_IN, 8, input pixel width; must be 8
- FIFO_DWIDTH_OUT, 8, output pixel width; must be 8
- WIDTH, 720, image width in pixels; minimum 3
- HEIGHT, 540, image height in pixels; minimum 3
- THRESHOLD, 64, binarization level; used only with SOBEL_THRESHOLD_EN
- clock  input  1  clock; all logic is rising-edge
- reset  input  1  reset, asynchronous, active-high
- fifo_in_rd_en  output  1  pop request to the input FIFO (FWFT)
- fifo_in_dout  input  FIFO_DWIDTH_IN  input FIFO head data
- fifo_in_empty  input  1  input FIFO empty
- fifo_out_wr_en  output  1  push to the output FIFO
- fifo_out_din  output  FIFO_DWIDTH_OUT  output pixel
- fifo_out_full  input  1  output FIFO full

## Operation
- **Line buffer:** a shift register of 2·WIDTH+3 pixels. Each "advance" shifts in one pixel: fifo_in_dout, or 0 during flush.
- **Window:** the 3×3 window is taken from taps 0..2, WIDTH..WIDTH+2 and 2·WIDTH..2·WIDTH+2. Its centre is tap WIDTH+1.
- **Output index:** output pixel k is computed on the advance that shifts in input pixel k+WIDTH+1.
- **FSM states:**
  - S_FILL: advances with writes suppressed. Moves to S_RUN after WIDTH+1 accepted pixels.
  - S_RUN: every advance produces one output. Moves to S_FLUSH after input pixel WIDTH·HEIGHT−1 is accepted.
  - S_FLUSH: advances WIDTH+1 times with no reads, shifting in zeros, and produces the remaining outputs. Then clears all counters and returns to S_FILL for the next frame.
- **Counters:** in_cnt (input pixels accepted), plus out_col/out_row (coordinates of the next output).
- **Border rule:** when out_row ∈ {0, HEIGHT−1} or out_col ∈ {0, WIDTH−1}, the output is 0. All flush outputs are border pixels.
- **Kernels:**
  - gx = (p02+2·p12+p22) − (p00+2·p10+p20)
  - gy = (p20+2·p21+p22) − (p00+2·p01+p02)
  - gx and gy are 11-bit signed, range ±1020.
- **Magnitude:** mag = (|gx|+|gy|)>>1, 11-bit unsigned, saturated to 255.
- **Output register:** out_valid plus out_data.
  - fifo_out_din = out_data.
  - fifo_out_wr_en = out_valid & ~fifo_out_full.
  - out_valid clears on write unless refilled in the same cycle.
- **Advance condition:** slot_free = ~out_valid | ~fifo_out_full.
  - S_FILL: advance = ~fifo_in_empty.
  - S_RUN: advance = ~fifo_in_empty & slot_free.
  - S_FLUSH: advance = slot_free.
  - fifo_in_rd_en = advance, except in S_FLUSH where it is 0. It is combinational.
- **Reset values:** fifo_in_rd_en 0, fifo_out_wr_en 0, fifo_out_din 0, out_valid 0, state S_FILL, all counters 0. Line buffer contents are don't-care, because borders mask stale data.

## Timing
- **Write timing:** a write occurs in the cycle after the advance that produced the output, provided fifo_out_full is low.
- **First-output latency:** output 0 is written one cycle after input pixel WIDTH+1 is accepted.
- **Throughput:** one pixel per clock with no stalls. There are no bubbles between S_FILL, S_RUN and S_FLUSH.
- **Empty or full stalls:** fifo_in_empty or fifo_out_full freezes the line buffer and counters. out_data is held and no data is lost or duplicated.
- **Simultaneous write and advance:** in the same cycle, the register accepts the new value and the old value is written.
- **Back-to-back frames:** the next frame's S_FILL reads start the cycle after the last flush advance.
- **Reset mid-frame:** the current frame is abandoned; the next pixel read is treated as frame pixel 0.

## Configuration
- **SOBEL_THRESHOLD_EN defined:** interior output is 255 if mag ≥ THRESHOLD, else 0. Borders remain 0.
- **Not defined:** output is the saturated magnitude and THRESHOLD is ignored.

## Structure
- **Shared package sobel_pkg:**
  - PIXEL_W = 8
  - state encodings S_FILL/S_RUN/S_FLUSH
  - kernel weights
  - the saturate-to-8-bit function
- **Sub-module sobel_line_buffer** (parameters WIDTH, PIXEL_W):
  - inputs: shift enable, pixel in
  - outputs: the nine window taps
- The FSM, counters, arithmetic and output register live in sobel_filter.

## Test plan
All scenarios use WIDTH=8 and HEIGHT=6 unless stated.
- **Constant image:** every pixel 100 → 48 writes, all 0.
- **Vertical step:** cols 0–3 = 0, cols 4–7 = 200 → interior cols 3 and 4 = 255 (|gx|=800), every other output 0.
- **Horizontal ramp:** pixel = 10·col → interior outputs 40, borders 0.
- **Backpressure:** fifo_out_full held high for 5 cycles, plus random fifo_in_empty gaps → no rd_en while stalled. The output stream must be bit-identical to the unstalled run, with exactly 48 writes.
- **Reset and back-to-back frames:** assert reset after 20 pixels, then send 2 full ramp frames → 96 correct writes. No write may occur during or immediately after reset.
- **Threshold build:** with SOBEL_THRESHOLD_EN and THRESHOLD=32, the ramp image → interior outputs 255, borders 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types, constants and helpers for the sobel pipeline stages.
package sobel_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Window index is row*3+col; row 0 is the oldest image line, col 0 the leftmost pixel.
    localparam int GX_W [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int GY_W [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    function automatic logic [PIXEL_W-1:0] sat8(input logic [10:0] v);
        return (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line-plus-three-pixel shift register exposing the 3x3 Sobel window.
// Tap 0 is the pixel being shifted in this cycle, so the window is complete on the advance itself.
module sobel_line_buffer #(
    parameter int WIDTH   = 720,
    parameter int PIXEL_W = sobel_pkg::PIXEL_W
) (
    input  logic               clock,
    input  logic               shift_en_i,
    input  logic [PIXEL_W-1:0] pix_i,
    output logic [PIXEL_W-1:0] win_o [9]
);

    localparam int DEPTH = 2 * WIDTH + 2;

    logic [PIXEL_W-1:0] line_q [DEPTH];

    always_ff @(posedge clock) begin
        if (shift_en_i) begin
            line_q[0] <= pix_i;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int TAP = (2 - gi / 3) * WIDTH + (2 - gi % 3);
            if (TAP == 0) begin : g_live
                assign win_o[gi] = pix_i;
            end else begin : g_stored
                assign win_o[gi] = line_q[TAP-1];
            end
        end
    endgenerate

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector between two FWFT FIFOs, one output pixel per input pixel.
// Define SOBEL_THRESHOLD_EN to binarize interior outputs against THRESHOLD.
module sobel_filter
    import sobel_pkg::*;
#(
    parameter int FIFO_DWIDTH_IN  = 8,
    parameter int FIFO_DWIDTH_OUT = 8,
    parameter int WIDTH           = 720,
    parameter int HEIGHT          = 540,
    parameter int THRESHOLD       = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       fifo_in_rd_en,
    input  logic [FIFO_DWIDTH_IN-1:0]  fifo_in_dout,
    input  logic                       fifo_in_empty,
    output logic                       fifo_out_wr_en,
    output logic [FIFO_DWIDTH_OUT-1:0] fifo_out_din,
    input  logic                       fifo_out_full
);

    localparam int CNT_W = $clog2(WIDTH * HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

`ifdef SOBEL_THRESHOLD_EN
    localparam bit BINARIZE = 1'b1;
`else
    localparam bit BINARIZE = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               out_valid_q, out_valid_d;
    logic [PIXEL_W-1:0] out_data_q, out_data_d;

    logic               slot_free;
    logic               advance;
    logic               border;
    logic               last_out;
    logic [PIXEL_W-1:0] lb_pix;
    logic [PIXEL_W-1:0] win [9];
    logic signed [10:0] gx, gy;
    logic [9:0]         abs_gx, abs_gy;
    logic [10:0]        mag;
    logic [PIXEL_W-1:0] mag_pix;

    assign lb_pix = (state_q == S_FLUSH) ? '0 : PIXEL_W'(fifo_in_dout);

    sobel_line_buffer #(
        .WIDTH   (WIDTH),
        .PIXEL_W (PIXEL_W)
    ) u_line_buffer (
        .clock      (clock),
        .shift_en_i (advance),
        .pix_i      (lb_pix),
        .win_o      (win)
    );

    always_comb begin
        gx = '0;
        gy = '0;
        for (int i = 0; i < 9; i++) begin
            gx = gx + 11'(GX_W[i] * int'(win[i]));
            gy = gy + 11'(GY_W[i] * int'(win[i]));
        end
        abs_gx  = gx[10] ? 10'(-gx) : 10'(gx);
        abs_gy  = gy[10] ? 10'(-gy) : 10'(gy);
        mag     = ({1'b0, abs_gx} + {1'b0, abs_gy}) >> 1;
        mag_pix = BINARIZE ? ((int'(mag) >= THRESHOLD) ? '1 : '0) : sat8(mag);
    end

    assign border   = (row_q == '0) || (row_q == ROW_W'(HEIGHT - 1)) ||
                      (col_q == '0) || (col_q == COL_W'(WIDTH - 1));
    assign last_out = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));

    assign slot_free      = ~out_valid_q | ~fifo_out_full;
    assign fifo_out_wr_en = out_valid_q & ~fifo_out_full;
    assign fifo_out_din   = FIFO_DWIDTH_OUT'(out_data_q);
    assign fifo_in_rd_en  = advance & (state_q != S_FLUSH);

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        advance     = 1'b0;

        // No pops while reset is held, so nothing is consumed from an abandoned frame.
        case (state_q)
            S_FILL:  advance = ~fifo_in_empty & ~reset;
            S_RUN:   advance = ~fifo_in_empty & slot_free & ~reset;
            S_FLUSH: advance = slot_free & ~reset;
            default: advance = 1'b0;
        endcase

        if (fifo_out_wr_en) begin
            out_valid_d = 1'b0;
        end

        if (advance) begin
            if (state_q == S_FILL) begin
                in_cnt_d = in_cnt_q + CNT_W'(1);
                if (in_cnt_q == CNT_W'(WIDTH)) begin
                    state_d = S_RUN;
                end
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = border ? '0 : mag_pix;
                if (col_q == COL_W'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                if (state_q == S_RUN) begin
                    if (in_cnt_q == CNT_W'(WIDTH * HEIGHT - 1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                    end
                end else if (last_out) begin
                    state_d  = S_FILL;
                    in_cnt_d = '0;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FILL;
            in_cnt_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
